// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 8-digit seven-segment scan arbiter.
//   seg_own_t  - display ownership state (nobody / source A / source B)
//   NUM_DIGITS - digits per scan frame (4 left + 4 right)
//   DIGIT_EN   - one-hot digit enable within a bank, indexed by idx[1:0]
//   SEG_OFF    - all segments dark
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } seg_own_t;

  localparam int NUM_DIGITS = 8;

  // Element 0 is the leftmost digit of a bank.
  localparam logic [3:0][3:0] DIGIT_EN = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: digit-slot prescaler and digit index for the scan frame.
//   clk_trl        in   clock
//   rst_n          in   synchronous reset, active-low
//   count          out  position inside the current digit slot, 0..CLK_DIV-1
//   idx            out  current digit, 0..7 (0 = leftmost left digit)
//   frame_boundary out  last cycle of the last slot of a frame
//   frame_done     out  high for the first cycle of each new frame
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int CW      = $clog2(CLK_DIV)
) (
  input  logic          clk_trl,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic [2:0]    idx,
  output logic          frame_boundary,
  output logic          frame_done
);

  logic tick;

  assign tick           = (count == CW'(CLK_DIV - 1));
  assign frame_boundary = tick && (idx == 3'(NUM_DIGITS - 1));

  always_ff @(posedge clk_trl) begin
    if (!rst_n) begin
      count      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      // 3-bit index wraps 7 -> 0 on its own.
      if (tick) idx <= idx + 1'b1;
      // Registering the boundary puts the pulse on the cycle where idx/count are back at 0.
      frame_done <= frame_boundary;
    end
  end

endmodule

// File: rtl/seg7_scan_arbiter.sv
// seg7_scan_arbiter: owns the two 4-digit seven-segment banks, grants one of two
// pattern sources per scan frame, latches its 64-bit frame and scans it out with
// anti-ghost blanking at the start of every digit slot.
//   clk_trl, rst_n         clock, synchronous active-low reset
//   req_a/frame_a          source A request + pattern (A wins ties from IDLE)
//   req_b/frame_b          source B request + pattern
//   bright                 3-bit brightness, only used with SEG_DIM_EN
//   gnt_a/gnt_b            current owner (one-hot or both 0)
//   frame_done             1-cycle pulse at each frame start
//   a_to_g_left/right      bank segments, bit7 = a .. bit1 = g, bit0 = dp
//   leftseg/rightseg       bank digit enables, 4'b1000 = leftmost
// Build option: define SEG_DIM_EN to PWM-dim the lit part of each slot by bright.
module seg7_scan_arbiter
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int BLANK_CYC  = 16,
  parameter int HOLD_SCANS = 64
) (
  input  logic        clk_trl,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [63:0] frame_a,
  input  logic        req_b,
  input  logic [63:0] frame_b,
  input  logic [2:0]  bright,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_done,
  output logic [7:0]  a_to_g_left,
  output logic [7:0]  a_to_g_right,
  output logic [3:0]  leftseg,
  output logic [3:0]  rightseg
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_SCANS + 1);

  logic [CW-1:0] count;
  logic [2:0]    idx;
  logic          frame_boundary;

  seg7_scan_timer #(.CLK_DIV(CLK_DIV), .CW(CW)) u_timer (
    .clk_trl        (clk_trl),
    .rst_n          (rst_n),
    .count          (count),
    .idx            (idx),
    .frame_boundary (frame_boundary),
    .frame_done     (frame_done)
  );

  // ---------------- arbiter ----------------
  seg_own_t                        state, state_nxt;
  logic [HW-1:0]                   hold, hold_inc;
  logic                            hold_expired;
  logic [NUM_DIGITS-1:0][7:0]      shadow;

  // hold_inc includes the frame that is completing right now, so the owner
  // yields at the boundary that ends its HOLD_SCANS-th frame.
  assign hold_inc     = (hold == HW'(HOLD_SCANS)) ? hold : hold + 1'b1;
  assign hold_expired = (hold_inc == HW'(HOLD_SCANS));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a)      state_nxt = OWN_A;
        else if (req_b) state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                     state_nxt = req_b ? OWN_B : IDLE;
        else if (req_b && hold_expired) state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                     state_nxt = req_a ? OWN_A : IDLE;
        else if (req_a && hold_expired) state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything here moves only at frame boundaries, so a frame is never torn.
  always_ff @(posedge clk_trl) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold   <= '0;
      shadow <= '0;
    end else if (frame_boundary) begin
      state <= state_nxt;
      hold  <= (state_nxt != state || state_nxt == IDLE) ? '0 : hold_inc;
      unique case (state_nxt)
        OWN_A:   shadow <= frame_a;
        OWN_B:   shadow <= frame_b;
        default: shadow <= '0;
      endcase
    end
  end

  // state is a flop, so the grants are registered.
  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);

  // ---------------- output mux / blank / dim ----------------
`ifdef SEG_DIM_EN
  logic [2:0] pwm;
  always_ff @(posedge clk_trl) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 1'b1;
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
`endif

  logic [7:0] digit_segs;
  logic [3:0] digit_en;
  logic       lit;
  logic [7:0] segl_d, segr_d;
  logic [3:0] enl_d, enr_d;

  assign digit_segs = shadow[3'(NUM_DIGITS - 1) - idx];
  assign digit_en   = DIGIT_EN[idx[1:0]];

  always_comb begin
    lit = (state != IDLE) && (count >= CW'(BLANK_CYC));
`ifdef SEG_DIM_EN
    // Blanking wins; dimming only trims the lit window.
    lit = lit && (pwm <= bright);
`endif
    segl_d = SEG_OFF;
    segr_d = SEG_OFF;
    enl_d  = '0;
    enr_d  = '0;
    if (lit) begin
      if (!idx[2]) begin
        segl_d = digit_segs;
        enl_d  = digit_en;
      end else begin
        segr_d = digit_segs;
        enr_d  = digit_en;
      end
    end
  end

  // Registered outputs: display trails count/idx by one cycle, durations unchanged.
  always_ff @(posedge clk_trl) begin
    if (!rst_n) begin
      a_to_g_left  <= SEG_OFF;
      a_to_g_right <= SEG_OFF;
      leftseg      <= '0;
      rightseg     <= '0;
    end else begin
      a_to_g_left  <= segl_d;
      a_to_g_right <= segr_d;
      leftseg      <= enl_d;
      rightseg     <= enr_d;
    end
  end

endmodule
